// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and coordinate widths for the VGA timing
// generator and the downstream text-mode index generator.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam logic HSYNC_POL = 1'b0;
    localparam logic VSYNC_POL = 1'b0;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam int X_W    = $clog2(H_ACTIVE);
    localparam int Y_W    = $clog2(V_ACTIVE);
    localparam int HCNT_W = $clog2(H_TOTAL);
    localparam int VCNT_W = $clog2(V_TOTAL);

    typedef logic [X_W-1:0] xpix_t;
    typedef logic [Y_W-1:0] ypix_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with clock enable and synchronous clear to the
// idle (last) position, plus active/sync window flags of the next position.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int ACTIVE     = H_ACTIVE,
    parameter int SYNC_START = HS_START,
    parameter int SYNC_END   = HS_END,
    parameter int W          = $clog2(TOTAL)
) (
    input  logic         clk_i,
    input  logic         arstn_i,
    input  logic         clr_i,
    input  logic         ce_i,
    output logic         last_o,
    output logic [W-1:0] cnt_next_o,
    output logic         active_next_o,
    output logic         sync_next_o
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT  = W'(ACTIVE);
    localparam logic [W-1:0] SS   = W'(SYNC_START);
    localparam logic [W-1:0] SE   = W'(SYNC_END);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LAST;
        end else if (ce_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags describe the position being entered so the top can register them
    // in the same edge as the counter.
    assign last_o        = (cnt_q == LAST);
    assign cnt_next_o    = cnt_d;
    assign active_next_o = (cnt_d < ACT);
    assign sync_next_o   = (cnt_d >= SS) && (cnt_d < SE);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: scans the full frame one pixel per pixel-clock
// enable and drives coordinates, syncs, active flag and start pulses from flops.
module vga_timing_gen #(
    parameter int   H_ACTIVE  = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP      = vga_timing_pkg::H_FP,
    parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int   H_BP      = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE  = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP      = vga_timing_pkg::V_FP,
    parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int   V_BP      = vga_timing_pkg::V_BP,
    parameter logic HSYNC_POL = vga_timing_pkg::HSYNC_POL,
    parameter logic VSYNC_POL = vga_timing_pkg::VSYNC_POL
) (
    input  logic                        clk_i,
    input  logic                        arstn_i,
    input  logic                        pix_ce_i,
    input  logic                        en_i,
    output logic [$clog2(H_ACTIVE)-1:0] xPixel_o,
    output logic [$clog2(V_ACTIVE)-1:0] yPixel_o,
    output logic                        hsync_o,
    output logic                        vsync_o,
    output logic                        active_o,
    output logic                        line_start_o,
    output logic                        frame_start_o
);

    localparam int H_TOTAL = vga_timing_pkg::axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_timing_pkg::axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);

    logic           adv;
    logic           h_last, v_last;
    logic [HCW-1:0] h_next;
    logic [VCW-1:0] v_next;
    logic           h_act_next, v_act_next, h_sync_next, v_sync_next;

    assign adv = en_i & pix_ce_i;

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC), .W(HCW)
    ) u_h_axis (
        .clk_i(clk_i), .arstn_i(arstn_i), .clr_i(~en_i), .ce_i(adv),
        .last_o(h_last), .cnt_next_o(h_next),
        .active_next_o(h_act_next), .sync_next_o(h_sync_next)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC), .W(VCW)
    ) u_v_axis (
        .clk_i(clk_i), .arstn_i(arstn_i), .clr_i(~en_i), .ce_i(adv & h_last),
        .last_o(v_last), .cnt_next_o(v_next),
        .active_next_o(v_act_next), .sync_next_o(v_sync_next)
    );

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

    // Clearing the counters to the idle corner makes every decode fall outside
    // the visible and sync windows, so en_i=0 needs no separate output path.
    always_comb begin
        x_d           = h_act_next ? XW'(h_next) : '0;
        y_d           = v_act_next ? YW'(v_next) : '0;
        active_d      = h_act_next & v_act_next;
        hsync_d       = h_sync_next ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = v_sync_next ? VSYNC_POL : ~VSYNC_POL;
        line_start_d  = adv & h_last;
        frame_start_d = adv & h_last & v_last;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            x_q           <= '0;
            y_q           <= '0;
            active_q      <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign xPixel_o      = x_q;
    assign yPixel_o      = y_q;
    assign active_o      = active_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance plus a short-frame instance (13 lines)
// so vertical sync and frame wrap can be observed in a few thousand clocks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic arstn = 1'b1;
    logic pix_ce = 1'b1;
    logic en = 1'b1;

    logic [9:0] x;
    logic [8:0] y;
    logic       hs, vs, act, ls, fs;

    logic [9:0] xs;
    logic [2:0] ys;
    logic       hss, vss, acts, lss, fss;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk_i(clk), .arstn_i(arstn), .pix_ce_i(pix_ce), .en_i(en),
        .xPixel_o(x), .yPixel_o(y), .hsync_o(hs), .vsync_o(vs),
        .active_o(act), .line_start_o(ls), .frame_start_o(fs)
    );

    // 800 x 13 frame: visible rows 0..5, vsync on rows 8..9, 10400 advances per frame.
    vga_timing_gen #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_s (
        .clk_i(clk), .arstn_i(arstn), .pix_ce_i(pix_ce), .en_i(en),
        .xPixel_o(xs), .yPixel_o(ys), .hsync_o(hss), .vsync_o(vss),
        .active_o(acts), .line_start_o(lss), .frame_start_o(fss)
    );

    task automatic chk(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got == exp) begin
            pass_cnt++;
            $display("pass %s = %0d", tag, got);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hlow, ls_cnt, fs_cnt, vlow, yerr, hold_err, ls_ce;
        logic [22:0] snap;
        hlow = 0; ls_cnt = 0; fs_cnt = 0; vlow = 0; yerr = 0; hold_err = 0; ls_ce = 0;

        #2 arstn = 1'b0;
        repeat (3) step();
        chk("rst_active", act, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_hsync", hs, 1);
        chk("rst_vsync", vs, 1);
        chk("rst_line_start", ls, 0);
        chk("rst_frame_start", fs, 0);

        @(negedge clk) arstn = 1'b1;
        step();
        chk("first_x", x, 0);
        chk("first_y", y, 0);
        chk("first_active", act, 1);
        chk("first_line_start", ls, 1);
        chk("first_frame_start", fs, 1);
        chk("first_s_frame_start", fss, 1);
        step();
        chk("second_x", x, 1);
        chk("second_line_start", ls, 0);
        chk("second_frame_start", fs, 0);

        for (int n = 2; n <= 10400; n++) begin
            step();
            if (n < 800 && !hs) hlow++;
            if (n < 10400) begin
                if (lss) ls_cnt++;
                if (fss) fs_cnt++;
                if (!vss) vlow++;
                if (n / 800 >= 6 && ys != 0) yerr++;
            end
            if (n == 639)  begin chk("x_at_639", x, 639); chk("active_at_639", act, 1); end
            if (n == 640)  begin chk("active_at_640", act, 0); chk("x_at_640", x, 0); end
            if (n == 655)  chk("hsync_at_655", hs, 1);
            if (n == 656)  chk("hsync_at_656", hs, 0);
            if (n == 751)  chk("hsync_at_751", hs, 0);
            if (n == 752)  chk("hsync_at_752", hs, 1);
            if (n == 800)  begin
                chk("line1_line_start", ls, 1);
                chk("line1_frame_start", fs, 0);
                chk("line1_x", x, 0);
                chk("line1_y", y, 1);
            end
            if (n == 2400) chk("line3_y", y, 3);
            if (n == 4000) begin chk("s_row5_y", ys, 5); chk("s_row5_active", acts, 1); end
            if (n == 4800) begin chk("s_row6_y", ys, 0); chk("s_row6_active", acts, 0); end
            if (n == 6399) chk("s_vsync_v7_end", vss, 1);
            if (n == 6400) chk("s_vsync_v8_start", vss, 0);
            if (n == 7999) chk("s_vsync_v9_end", vss, 0);
            if (n == 8000) chk("s_vsync_v10_start", vss, 1);
        end
        chk("hsync_low_pixels", hlow, 96);
        chk("s_line_starts_in_frame", ls_cnt, 12);
        chk("s_frame_starts_in_frame", fs_cnt, 0);
        chk("s_vsync_low_advances", vlow, 1600);
        chk("s_y_blank_nonzero", yerr, 0);
        chk("s_wrap_frame_start", fss, 1);
        chk("s_wrap_line_start", lss, 1);
        chk("s_wrap_x", xs, 0);
        chk("s_wrap_y", ys, 0);
        chk("s_wrap_active", acts, 1);
        chk("big_v13_y", y, 13);
        chk("big_v13_frame_start", fs, 0);

        // Pixel enable at 1 in 4 clocks for one full line.
        for (int c = 0; c < 3200; c++) begin
            snap = {x, y, act, hs, vs, 1'b0};
            pix_ce = (c % 4 == 0);
            step();
            if (!pix_ce && ({x, y, act, hs, vs, 1'b0} != snap)) hold_err++;
            if (ls) ls_ce++;
        end
        pix_ce = 1'b1;
        chk("ce_hold_violations", hold_err, 0);
        chk("ce_line_start_clks", ls_ce, 1);
        chk("ce_end_x", x, 0);
        chk("ce_end_y", y, 14);

        repeat (300) step();
        chk("pre_disable_x", x, 300);
        chk("pre_disable_active", act, 1);
        en = 1'b0;
        step();
        chk("disable_active", act, 0);
        chk("disable_hsync", hs, 1);
        chk("disable_vsync", vs, 1);
        chk("disable_x", x, 0);
        chk("disable_y", y, 0);
        step();
        chk("disable_hold_line_start", ls, 0);
        en = 1'b1;
        step();
        chk("reenable_x", x, 0);
        chk("reenable_y", y, 0);
        chk("reenable_active", act, 1);
        chk("reenable_frame_start", fs, 1);
        step();
        chk("reenable_next_x", x, 1);

        repeat (655) step();
        chk("pre_arst_hsync", hs, 0);
        #2 arstn = 1'b0;
        #1;
        chk("arst_hsync_immediate", hs, 1);
        chk("arst_active_immediate", act, 0);
        chk("arst_x_immediate", x, 0);
        repeat (2) step();
        @(negedge clk) arstn = 1'b1;
        step();
        chk("post_arst_x", x, 0);
        chk("post_arst_y", y, 0);
        chk("post_arst_frame_start", fs, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the text-mode index generator.
- Scans the 800x525 total frame (640x480 visible) one pixel per pixel-clock-enable.
- Produces the xPixel/yPixel coordinates the index generator consumes, plus hsync/vsync, a display-active flag and line/frame start pulses.
- Downstream stages (char RAM, font ROM, colour mux) align to these outputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync_o
- VSYNC_POL, 0, asserted level of vsync_o

Ports:
- clk_i  in  1  system clock
- arstn_i  in  1  asynchronous active-low reset
- pix_ce_i  in  1  pixel clock enable; one raster advance per clk with pix_ce_i=1
- en_i  in  1  generator enable
- xPixel_o  out  $clog2(H_ACTIVE)  current visible column
- yPixel_o  out  $clog2(V_ACTIVE)  current visible row
- hsync_o  out  1  horizontal sync at HSYNC_POL
- vsync_o  out  1  vertical sync at VSYNC_POL
- active_o  out  1  position is inside the visible area
- line_start_o  out  1  one-clk pulse on entry to h=0
- frame_start_o  out  1  one-clk pulse on entry to (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters hcnt (0..H_TOTAL-1) and vcnt (0..V_TOTAL-1) define the position (h,v).
- Advance occurs on a clk edge with en_i=1 and pix_ce_i=1:
  - h == H_TOTAL-1: h->0, and v->(v==V_TOTAL-1 ? 0 : v+1).
  - Otherwise h->h+1.
- No advance when pix_ce_i=0: all outputs hold, except the pulses described below.
- All outputs come directly from flops, updated in the same edge as the counters. This gives zero cycles between the position change and the output change, and no combinational glitches on the sync pins.
- Output functions of the new position (h,v):
  - active_o = (h<H_ACTIVE) && (v<V_ACTIVE).
  - xPixel_o = h if h<H_ACTIVE, else 0.
  - yPixel_o = v if v<V_ACTIVE, else 0.
  - hsync_o = HSYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751), else ~HSYNC_POL.
  - vsync_o = VSYNC_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), else ~VSYNC_POL.
- Pulses:
  - line_start_o = 1 for exactly the one clk following an advance into h=0.
  - frame_start_o = 1 for exactly the one clk following an advance into (0,0). line_start_o is also 1 in that clk.
  - Both pulses clear on the next clk regardless of pix_ce_i.
- Reset (arstn_i=0, asynchronous):
  - Counters go to the idle position (H_TOTAL-1, V_TOTAL-1).
  - active_o=0, xPixel_o=0, yPixel_o=0.
  - hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL.
  - line_start_o=0, frame_start_o=0.
- First advance after reset release lands on (0,0): outputs active_o=1, x=0, y=0, and both pulses fire.
- en_i=0: synchronously forces the reset state on the next clk edge, ignoring pix_ce_i.
- en_i re-asserted: the next advance lands on (0,0) with frame_start_o.
- Reset or en_i deassertion mid-frame abandons the frame; no partial sync pulse is extended.
- Simultaneous en_i=0 and pix_ce_i=1: en_i wins.
- Width rule: counters are $clog2(H_TOTAL) and $clog2(V_TOTAL) bits wide. Comparisons use full counter width; the truncation to xPixel_o/yPixel_o widths happens only inside the visible range.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the 640x480@60 constants (active, porch and sync widths, totals, polarities);
  - derived localparams: HS_START=656, HS_END=752, VS_START=490, VS_END=492;
  - coordinate width constants used by both this block and the index generator.
- One natural sub-module, vga_axis_counter, instantiated once for h and once for v. It is a wrap counter with ce and sync clear, and outputs the active/sync window flags for its axis.

Test Plan:
- Reset release, en_i=1, pix_ce_i=1 every clk:
  - first edge gives x=0, y=0, active_o=1, line_start_o=1, frame_start_o=1;
  - the next clk shows both pulses 0 and x=1.
- Full line scan:
  - active_o falls after x=639;
  - hsync_o goes 0 on the 657th advance of the line (h=656) and returns 1 at h=752 (96 pixels low);
  - line_start_o repeats every 800 advances.
- Full frame scan:
  - vsync_o is low exactly during lines 490-491 (1600 advances);
  - yPixel_o is held at 0 for v>=480;
  - frame_start_o repeats every 420000 advances.
- pix_ce_i pulsing 1-of-4 (100 MHz clk):
  - outputs change only on ce edges;
  - line_start_o is a single-clk pulse, not four clks wide.
- en_i deasserted mid-line (h=300, v=100):
  - the next edge gives the idle outputs (active_o=0, syncs high);
  - after re-enable, the first advance gives (0,0) with frame_start_o=1.
- arstn_i asserted asynchronously while hsync_o is low: hsync_o rises immediately without waiting for a clk edge; the counters reach idle.
